// File: rtl/cv32e40p_register_file_mp.sv
// cv32e40p_register_file_mp: multi-port flip-flop register file with byte-enabled writes, optional bypass, busy scoreboard and bulk clear
// ports: clk, rst_n (async, active low); raddr_i/rdata_o/rbusy_o read ports; we_i/waddr_i/wdata_i/wbe_i write ports;
//        rsv_valid_i/rsv_addr_i/rsv_ready_o reservation; clr_req_i/clr_busy_o/clr_done_o bulk clear
module cv32e40p_register_file_mp #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NR_RPORTS  = 3,
  parameter int NR_WPORTS  = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NR_RPORTS*ADDR_WIDTH-1:0]  raddr_i,
  output logic [NR_RPORTS*DATA_WIDTH-1:0]  rdata_o,
  output logic [NR_RPORTS-1:0]             rbusy_o,
  input  logic [NR_WPORTS-1:0]             we_i,
  input  logic [NR_WPORTS*ADDR_WIDTH-1:0]  waddr_i,
  input  logic [NR_WPORTS*DATA_WIDTH-1:0]  wdata_i,
  input  logic [NR_WPORTS*DATA_WIDTH/8-1:0] wbe_i,
  input  logic                             rsv_valid_i,
  input  logic [ADDR_WIDTH-1:0]            rsv_addr_i,
  output logic                             rsv_ready_o,
  input  logic                             clr_req_i,
  output logic                             clr_busy_o,
  output logic                             clr_done_o
);
  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam int NB = DATA_WIDTH / 8;
  localparam bit ZR = ZERO_REG != 0;
  typedef enum logic {IDLE, CLEAR} state_e;
  state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] mem_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic rsv_acc;
  assign clr_busy_o = state_q == CLEAR;
  assign clr_done_o = clr_busy_o && &cnt_q;
  assign rsv_ready_o = state_q == IDLE && !busy_q[rsv_addr_i] && !(ZR && rsv_addr_i == '0);
  assign rsv_acc = rsv_valid_i && rsv_ready_o;
  always_comb begin
    state_d = state_q == IDLE ? (clr_req_i ? CLEAR : IDLE) : (&cnt_q ? IDLE : CLEAR);
    cnt_d = state_q == CLEAR ? cnt_q + 1'b1 : '0;
  end
  // ports are applied in ascending order so the highest index wins each byte lane
  always_comb begin
    mem_d = mem_q;
    busy_d = busy_q;
    for (int w = 0; w < NR_WPORTS; w++)
      if (we_i[w] && !(ZR && waddr_i[w*ADDR_WIDTH +: ADDR_WIDTH] == '0)) begin
        busy_d[waddr_i[w*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
        for (int b = 0; b < NB; b++)
          if (wbe_i[w*NB+b])
            mem_d[waddr_i[w*ADDR_WIDTH +: ADDR_WIDTH]][b*8 +: 8] = wdata_i[w*DATA_WIDTH+b*8 +: 8];
      end
    if (rsv_acc) busy_d[rsv_addr_i] = 1'b1;
    if (state_q == CLEAR) begin
      mem_d[cnt_q] = '0;
      busy_d[cnt_q] = 1'b0;
    end
  end
  always_comb begin
    rdata_o = '0;
    rbusy_o = '0;
    for (int p = 0; p < NR_RPORTS; p++) begin
      rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = mem_q[raddr_i[p*ADDR_WIDTH +: ADDR_WIDTH]];
      rbusy_o[p] = busy_q[raddr_i[p*ADDR_WIDTH +: ADDR_WIDTH]];
      if (BYPASS != 0)
        for (int w = 0; w < NR_WPORTS; w++)
          for (int b = 0; b < NB; b++)
            if (we_i[w] && wbe_i[w*NB+b] && waddr_i[w*ADDR_WIDTH +: ADDR_WIDTH] == raddr_i[p*ADDR_WIDTH +: ADDR_WIDTH])
              rdata_o[p*DATA_WIDTH+b*8 +: 8] = wdata_i[w*DATA_WIDTH+b*8 +: 8];
      if (ZR && raddr_i[p*ADDR_WIDTH +: ADDR_WIDTH] == '0) begin
        rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = '0;
        rbusy_o[p] = 1'b0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      mem_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
      busy_q <= busy_d;
    end
endmodule

// File: tb/tb_cv32e40p_register_file_mp.sv
// tb_cv32e40p_register_file_mp: directed self-checking bench for the multi-port register file (plain and bypass instances)
module tb_cv32e40p_register_file_mp;
  logic clk = 1'b0;
  logic rst_n;
  logic [14:0] raddr;
  logic [1:0] we;
  logic [9:0] waddr;
  logic [63:0] wdata;
  logic [7:0] wbe;
  logic rsv_valid;
  logic [4:0] rsv_addr;
  logic clr_req;
  logic [95:0] a_rdata, b_rdata;
  logic [2:0] a_rbusy, b_rbusy;
  logic a_rsv_ready, b_rsv_ready, a_clr_busy, b_clr_busy, a_clr_done, b_clr_done;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  cv32e40p_register_file_mp #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NR_RPORTS(3), .NR_WPORTS(2), .ZERO_REG(1), .BYPASS(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .raddr_i(raddr), .rdata_o(a_rdata), .rbusy_o(a_rbusy),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .wbe_i(wbe),
    .rsv_valid_i(rsv_valid), .rsv_addr_i(rsv_addr), .rsv_ready_o(a_rsv_ready),
    .clr_req_i(clr_req), .clr_busy_o(a_clr_busy), .clr_done_o(a_clr_done));
  cv32e40p_register_file_mp #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NR_RPORTS(3), .NR_WPORTS(2), .ZERO_REG(1), .BYPASS(1)) u_byp (
    .clk(clk), .rst_n(rst_n), .raddr_i(raddr), .rdata_o(b_rdata), .rbusy_o(b_rbusy),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .wbe_i(wbe),
    .rsv_valid_i(rsv_valid), .rsv_addr_i(rsv_addr), .rsv_ready_o(b_rsv_ready),
    .clr_req_i(clr_req), .clr_busy_o(b_clr_busy), .clr_done_o(b_clr_done));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input int w, input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    we[w] = 1'b1;
    waddr[w*5 +: 5] = a;
    wdata[w*32 +: 32] = d;
    wbe[w*4 +: 4] = be;
  endtask
  task automatic rd(input int p, input logic [4:0] a);
    raddr[p*5 +: 5] = a;
  endtask
  function automatic logic [31:0] ra(input int p);
    return a_rdata[p*32 +: 32];
  endfunction
  function automatic logic [31:0] rb(input int p);
    return b_rdata[p*32 +: 32];
  endfunction
  initial begin
    int k, done_n, done_k, busy_n;
    logic [31:0] acc;
    logic [2:0] bacc;
    rst_n = 1'b0; raddr = '0; we = '0; waddr = '0; wdata = '0; wbe = '0;
    rsv_valid = 1'b0; rsv_addr = 5'd1; clr_req = 1'b0;
    #1;
    rd(0, 5'd5);
    #1;
    chk("reset_rdata", ra(0), 32'h0);
    chk("reset_rbusy", {29'd0, a_rbusy}, 32'h0);
    chk("reset_clr_busy", {31'd0, a_clr_busy}, 32'h0);
    chk("reset_clr_done", {31'd0, a_clr_done}, 32'h0);
    chk("reset_rsv_ready_r1", {31'd0, a_rsv_ready}, 32'h1);
    rsv_addr = 5'd0;
    #1;
    chk("reset_rsv_ready_r0", {31'd0, a_rsv_ready}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    // basic write, visible next cycle without bypass, same cycle with bypass
    wr(0, 5'd5, 32'hDEADBEEF, 4'hF);
    rd(1, 5'd5);
    #1;
    chk("nobyp_same_cycle", ra(1), 32'h0);
    chk("byp_same_cycle", rb(1), 32'hDEADBEEF);
    tick;
    we = '0;
    #1;
    chk("write_r5", ra(1), 32'hDEADBEEF);
    // collision on r7: port1 wins its two low bytes
    wr(0, 5'd7, 32'h11111111, 4'hF);
    wr(1, 5'd7, 32'h00002222, 4'h3);
    rd(0, 5'd7);
    #1;
    chk("byp_collision", rb(0), 32'h11112222);
    tick;
    we = '0;
    #1;
    chk("collision_r7", ra(0), 32'h11112222);
    wr(0, 5'd7, 32'hAA000000, 4'h8);
    tick;
    we = '0;
    #1;
    chk("partial_byte_r7", ra(0), 32'hAA112222);
    // zero register
    wr(1, 5'd0, 32'hFFFFFFFF, 4'hF);
    rd(2, 5'd0);
    tick;
    we = '0;
    #1;
    chk("zero_reg_read", ra(2), 32'h0);
    chk("zero_reg_read_byp", rb(2), 32'h0);
    rsv_valid = 1'b1; rsv_addr = 5'd0;
    #1;
    chk("zero_reg_rsv_ready", {31'd0, a_rsv_ready}, 32'h0);
    // scoreboard
    rsv_addr = 5'd3;
    rd(2, 5'd3);
    #1;
    chk("rsv_ready_r3_free", {31'd0, a_rsv_ready}, 32'h1);
    tick;
    rsv_valid = 1'b0;
    #1;
    chk("rbusy_r3_set", {31'd0, a_rbusy[2]}, 32'h1);
    chk("rsv_ready_r3_busy", {31'd0, a_rsv_ready}, 32'h0);
    wr(1, 5'd3, 32'h00000033, 4'h0);
    tick;
    we = '0;
    #1;
    chk("write_clears_busy", {31'd0, a_rbusy[2]}, 32'h0);
    chk("wbe0_no_data", ra(2), 32'h0);
    rsv_valid = 1'b1;
    wr(0, 5'd3, 32'h12345678, 4'hF);
    tick;
    rsv_valid = 1'b0; we = '0;
    #1;
    chk("rsv_and_write_busy", {31'd0, a_rbusy[2]}, 32'h1);
    chk("rsv_and_write_data", ra(2), 32'h12345678);
    // bypass
    wr(0, 5'd9, 32'hCAFE0000, 4'hF);
    rd(0, 5'd9);
    #1;
    chk("byp_r9", rb(0), 32'hCAFE0000);
    chk("nobyp_r9", ra(0), 32'h0);
    tick;
    we = '0;
    // fill registers and reserve r4, then bulk clear
    for (int i = 0; i < 32; i++) begin
      wr(0, 5'(i), 32'h100 + i, 4'hF);
      tick;
    end
    we = '0;
    rsv_valid = 1'b1; rsv_addr = 5'd4;
    tick;
    rsv_valid = 1'b0;
    rd(1, 5'd4);
    #1;
    chk("fill_r4_busy", {31'd0, a_rbusy[1]}, 32'h1);
    chk("fill_r4_data", ra(1), 32'h104);
    clr_req = 1'b1;
    tick;
    k = 0; done_n = 0; done_k = -1;
    while (a_clr_busy && k < 40) begin
      clr_req = k < 6;
      we = '0;
      if (k == 10) wr(0, 5'd20, 32'hABCD0020, 4'hF);
      rd(0, 5'd20);
      rsv_addr = 5'd1; rsv_valid = 1'b1;
      #1;
      if (k == 3) chk("clear_rsv_refused", {31'd0, a_rsv_ready}, 32'h0);
      if (k == 20) chk("clear_r20_survives", ra(0), 32'hABCD0020);
      if (k == 21) chk("clear_r20_zeroed", ra(0), 32'h0);
      if (a_clr_done) begin done_n++; done_k = k; end
      tick;
      k++;
    end
    we = '0; clr_req = 1'b0; rsv_valid = 1'b0;
    chk("clear_cycles", k, 32);
    chk("clear_done_count", done_n, 1);
    chk("clear_done_cycle", done_k, 31);
    acc = '0; bacc = '0;
    for (int i = 0; i < 32; i++) begin
      rd(0, 5'(i)); rd(1, 5'(i)); rd(2, 5'(i));
      #1;
      acc |= ra(0);
      bacc |= a_rbusy;
    end
    chk("clear_all_data_zero", acc, 32'h0);
    chk("clear_all_busy_zero", {29'd0, bacc}, 32'h0);
    // reset in the middle of a clear
    wr(0, 5'd30, 32'h30303030, 4'hF);
    rsv_valid = 1'b1; rsv_addr = 5'd31;
    tick;
    we = '0; rsv_valid = 1'b0;
    clr_req = 1'b1;
    tick;
    clr_req = 1'b0;
    repeat (12) tick;
    chk("midclear_busy", {31'd0, a_clr_busy}, 32'h1);
    rst_n = 1'b0;
    rd(0, 5'd30); rd(1, 5'd31);
    #1;
    chk("midclear_reset_idle", {31'd0, a_clr_busy}, 32'h0);
    chk("midclear_reset_r30", ra(0), 32'h0);
    chk("midclear_reset_busy31", {31'd0, a_rbusy[1]}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_n = 0; busy_n = 0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (a_clr_done) done_n++;
      if (a_clr_busy) busy_n++;
    end
    chk("midclear_no_done", done_n, 0);
    chk("midclear_stays_idle", busy_n, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
